// File: rtl/serializer_piso_param.sv
// Parametrised parallel-in/serial-out serializer with valid/ready load and per-bit strobe.
// Optional even-parity bit after the data word when SERIALIZER_PARITY_EN is defined.
module serializer_piso_param #(
  parameter int   DATA_WIDTH = 8,
  parameter int   BIT_CYCLES = 1,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic                  sdata,
  output logic                  tx_active,
  output logic                  bit_strobe,
  output logic                  tx_done
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int DIV_W = $clog2(BIT_CYCLES + 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_CYCLES - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_PARITY} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;
`endif

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next, shift_adv;
  logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;
  logic                  sdata_reg, sdata_next;
  logic                  div_last, bit_last, word_end, can_load;
`ifdef SERIALIZER_PARITY_EN
  logic                  parity_reg, parity_next;
`endif

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_adv = {shift_reg[DATA_WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign shift_adv = {1'b0, shift_reg[DATA_WIDTH-1:1]};
    end
  endgenerate

  assign div_last = (div_cnt_reg == DIV_LAST);
  assign bit_last = (bit_cnt_reg == BIT_LAST);
`ifdef SERIALIZER_PARITY_EN
  assign word_end = (state_reg == ST_PARITY) && div_last;
`else
  assign word_end = (state_reg == ST_SHIFT) && div_last && bit_last;
`endif
  // A new word may load from idle or on the final clock of the current word.
  assign can_load = (state_reg == ST_IDLE) || word_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      sdata_reg   <= IDLE_LEVEL;
`ifdef SERIALIZER_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      bit_cnt_reg <= bit_cnt_next;
      div_cnt_reg <= div_cnt_next;
      sdata_reg   <= sdata_next;
`ifdef SERIALIZER_PARITY_EN
      parity_reg  <= parity_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt_reg;
    div_cnt_next = div_cnt_reg;
`ifdef SERIALIZER_PARITY_EN
    parity_next  = parity_reg;
`endif
    if (can_load && din_valid) begin
      state_next   = ST_SHIFT;
      shift_next   = din;
      bit_cnt_next = '0;
      div_cnt_next = '0;
`ifdef SERIALIZER_PARITY_EN
      parity_next  = ^din;
`endif
    end else begin
      case (state_reg)
        ST_SHIFT: begin
          if (!div_last) begin
            div_cnt_next = div_cnt_reg + DIV_W'(1);
          end else begin
            div_cnt_next = '0;
            if (!bit_last) begin
              shift_next   = shift_adv;
              bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            end else begin
              bit_cnt_next = '0;
`ifdef SERIALIZER_PARITY_EN
              state_next   = ST_PARITY;
`else
              state_next   = ST_IDLE;
`endif
            end
          end
        end
`ifdef SERIALIZER_PARITY_EN
        ST_PARITY: begin
          if (!div_last) begin
            div_cnt_next = div_cnt_reg + DIV_W'(1);
          end else begin
            div_cnt_next = '0;
            state_next   = ST_IDLE;
          end
        end
`endif
        default: state_next = ST_IDLE;
      endcase
    end

    // sdata is registered, so it is derived from the state being entered.
    sdata_next = IDLE_LEVEL;
    if (state_next == ST_SHIFT) begin
      sdata_next = MSB_FIRST ? shift_next[DATA_WIDTH-1] : shift_next[0];
    end
`ifdef SERIALIZER_PARITY_EN
    if (state_next == ST_PARITY) begin
      sdata_next = parity_next;
    end
`endif
  end

  always_comb begin
    sdata      = sdata_reg;
    tx_active  = (state_reg != ST_IDLE);
    bit_strobe = !rst && (state_reg != ST_IDLE) && (div_cnt_reg == '0);
    tx_done    = !rst && word_end;
    din_ready  = !rst && can_load;
  end

endmodule
